// File: rtl/pipe_mux_if.sv
// Handshake bundle for pipe_mux: lane offer on the upstream side, registered word on the downstream side.
interface pipe_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [7:0]              err_cnt;

  modport master (
    output data_in, sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err, err_cnt
  );

  modport slave (
    input  data_in, sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err, err_cnt
  );
endinterface

// File: rtl/pipe_mux.sv
// Registered lane selector with a head+skid store so in_ready never depends on out_ready.
// Optional feature: define PIPE_MUX_ERR_CNT_EN to get the saturating out-of-range select counter.
module pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input logic     clk,
  input logic     rst_n,
  pipe_mux_if.slave bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] head_data_reg;
  logic             head_err_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_err_reg;
  logic             out_valid_reg;
  logic             in_ready_reg;

  logic [WIDTH-1:0] lanes [NUM_IN];
  logic [WIDTH-1:0] lane_word;
  logic             sel_bad;
  logic             accept;
  logic             consume;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    assign lanes[gi] = bus.data_in[gi*WIDTH +: WIDTH];
  end

  // An out-of-range select matches no lane, so the word falls through to zero.
  always_comb begin
    lane_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) lane_word = lanes[k];
    end
  end

  assign sel_bad = !(32'(bus.sel) < NUM_IN);
  assign accept  = bus.in_valid && in_ready_reg;
  assign consume = out_valid_reg && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      head_data_reg <= '0;
      head_err_reg  <= 1'b0;
      skid_data_reg <= '0;
      skid_err_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      in_ready_reg <= 1'b1;
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            head_data_reg <= lane_word;
            head_err_reg  <= sel_bad;
            out_valid_reg <= 1'b1;
            state_reg     <= ONE;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            skid_data_reg <= lane_word;
            skid_err_reg  <= sel_bad;
            in_ready_reg  <= 1'b0;
            state_reg     <= FULL;
          end else if (accept && consume) begin
            head_data_reg <= lane_word;
            head_err_reg  <= sel_bad;
          end else if (consume) begin
            // Clearing the tag keeps sel_err low whenever nothing is presented.
            head_err_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            state_reg     <= EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            head_data_reg <= skid_data_reg;
            head_err_reg  <= skid_err_reg;
            state_reg     <= ONE;
          end else begin
            in_ready_reg  <= 1'b0;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          head_err_reg  <= 1'b0;
          state_reg     <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = head_data_reg;
  assign bus.sel_err   = head_err_reg;

`ifdef PIPE_MUX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= 8'd0;
    end else if (accept && sel_bad && (err_cnt_reg != 8'hff)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_reg;
`else
  assign bus.err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// Scoreboard bench for pipe_mux: directed corner cases followed by a randomized handshake soak.
module tb_pipe_mux;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;
`ifdef PIPE_MUX_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } word_t;

  logic clk;
  logic rst_n;
  pipe_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

  pipe_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    checks = 0;
  int    errors = 0;
  bit    verbose = 1'b1;
  word_t exp_q[$];
  int    err_model = 0;
  bit    held = 1'b0;
  word_t held_w;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the word is lane sel shifted out of the flat bus, or zero with the tag set.
  function automatic word_t model_word(input logic [NUM_IN*WIDTH-1:0] din, input int s);
    logic [NUM_IN*WIDTH-1:0] sh;
    word_t w;
    if (s < NUM_IN) begin
      sh = din >> (s * WIDTH);
      w.data = sh[WIDTH-1:0];
      w.err  = 1'b0;
    end else begin
      w.data = '0;
      w.err  = 1'b1;
    end
    return w;
  endfunction

  always @(negedge clk) begin : sb_push
    if (!rst_n) begin
      exp_q.delete();
      err_model = 0;
    end else begin
      chk("err_cnt", {56'd0, bus.err_cnt}, ERR_EN ? 64'(err_model) : 64'd0);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model_word(bus.data_in, int'(bus.sel)));
        if (int'(bus.sel) >= NUM_IN && err_model < 255) err_model++;
      end
    end
  end

  always @(negedge clk) begin : sb_mon
    word_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else if (bus.out_valid) begin
      if (held) begin
        chk("stable_data", {32'd0, bus.out_data}, {32'd0, held_w.data});
        chk("stable_err", {63'd0, bus.sel_err}, {63'd0, held_w.err});
      end
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", bus.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
          chk("sel_err", {63'd0, bus.sel_err}, {63'd0, e.err});
          if (verbose) $display("word out data=%08h sel_err=%0b t=%0t", bus.out_data, bus.sel_err, $time);
        end
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_w = {bus.sel_err, bus.out_data};
      end
    end else begin
      chk("sel_err_idle", {63'd0, bus.sel_err}, 64'd0);
      if (held) chk("valid_held", {63'd0, bus.out_valid}, 64'd1);
      held = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.sel      = '0;
    bus.data_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    chk("rst_sel_err", {63'd0, bus.sel_err}, 64'd0);
    chk("rst_err_cnt", {56'd0, bus.err_cnt}, 64'd0);
    #2 rst_n = 1'b1;
    step();
    chk("ready_after_release", {63'd0, bus.in_ready}, 64'd1);

    // Streaming through all three lanes at full rate.
    bus.out_ready = 1'b1;
    bus.data_in = {32'h33, 32'h22, 32'h11};
    bus.in_valid = 1'b1;
    bus.sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stream_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("stream_data", {32'd0, bus.out_data}, 64'(32'h11 * (i + 1)));
      if (i < 2) bus.sel = SEL_W'(i + 1);
      else bus.in_valid = 1'b0;
    end
    step();

    // Backpressure fills the skid; words drain in order.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.sel = 2'd0;
    bus.data_in = {32'hcccc0003, 32'hbbbb0002, 32'haaaa0001};
    step();
    chk("bp_head_a", {32'd0, bus.out_data}, 64'haaaa0001);
    chk("bp_ready_one", {63'd0, bus.in_ready}, 64'd1);
    bus.sel = 2'd1;
    step();
    chk("bp_full_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_full_a", {32'd0, bus.out_data}, 64'haaaa0001);
    bus.sel = 2'd2;
    step();
    chk("bp_blocked_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_blocked_a", {32'd0, bus.out_data}, 64'haaaa0001);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_drain_b", {32'd0, bus.out_data}, 64'hbbbb0002);
    chk("bp_ready_back", {63'd0, bus.in_ready}, 64'd1);
    step();
    chk("bp_empty", {63'd0, bus.out_valid}, 64'd0);

    // Out-of-range select.
    bus.in_valid = 1'b1;
    bus.sel = 2'd3;
    step();
    bus.in_valid = 1'b0;
    chk("bad_sel_data", {32'd0, bus.out_data}, 64'd0);
    chk("bad_sel_err", {63'd0, bus.sel_err}, 64'd1);
    chk("bad_sel_cnt", {56'd0, bus.err_cnt}, ERR_EN ? 64'd1 : 64'd0);
    step();

    // Counter saturation.
    bus.in_valid = 1'b1;
    bus.sel = 2'd3;
    repeat (300) step();
    bus.in_valid = 1'b0;
    step();
    step();
    chk("err_cnt_sat", {56'd0, bus.err_cnt}, ERR_EN ? 64'd255 : 64'd0);

    // Asynchronous reset while FULL.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.sel = 2'd3;
    step();
    bus.sel = 2'd0;
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_full", {63'd0, bus.in_ready}, 64'd0);
    chk("pre_rst_err", {63'd0, bus.sel_err}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("async_sel_err", {63'd0, bus.sel_err}, 64'd0);
    chk("async_err_cnt", {56'd0, bus.err_cnt}, 64'd0);
    chk("async_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("async_data", {32'd0, bus.out_data}, 64'd0);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.sel = 2'd1;
    rst_n = 1'b1;
    #1;
    chk("release_ready_low", {63'd0, bus.in_ready}, 64'd0);
    step();
    bus.in_valid = 1'b0;
    chk("release_ready_high", {63'd0, bus.in_ready}, 64'd1);
    chk("release_no_accept", {63'd0, bus.out_valid}, 64'd0);

    // Randomized soak.
    verbose = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.sel       = SEL_W'($urandom_range(0, 3));
      bus.data_in   = {$urandom, $urandom, $urandom};
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 20) begin
      step();
      n++;
    end
    step();
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", {63'd0, bus.out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
